// File: rtl/comparador_pkg.sv
// comparador_pkg: shared definitions for the bit-serial magnitude comparator.
//   - estado_t  : FSM states (ESPERA, COMPARA, FIN)
//   - RES_*     : one-hot result codes {A_mayor, B_mayor, iguales}
//   - calc_iw() : width of the bit index for a K-bit operand (minimum 1)
package comparador_pkg;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    COMPARA = 2'd1,
    FIN     = 2'd2
  } estado_t;

  // Result register layout: bit 2 = A_mayor, bit 1 = B_mayor, bit 0 = iguales.
  localparam logic [2:0] RES_NINGUNO = 3'b000;
  localparam logic [2:0] RES_A_MAYOR = 3'b100;
  localparam logic [2:0] RES_B_MAYOR = 3'b010;
  localparam logic [2:0] RES_IGUALES = 3'b001;

  // A 1-bit operand still needs a 1-bit index field.
  function automatic int calc_iw(input int k);
    return (k <= 1) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/comparador_serial_contador.sv
// contador_bits: down-counter that walks the bit index from the MSB to bit 0.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset (count -> 0)
//   i_carga      in   load i_valor (has priority over decrement)
//   i_valor      in   IW  value to load
//   i_decrementa in   decrement by one
//   o_cuenta     out  IW  current count
//   o_cero       out  count is zero
module contador_bits #(
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_carga,
  input  logic [IW-1:0] i_valor,
  input  logic          i_decrementa,
  output logic [IW-1:0] o_cuenta,
  output logic          o_cero
);

  logic [IW-1:0] r_cuenta;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cuenta <= '0;
    end else if (i_carga) begin
      r_cuenta <= i_valor;
    end else if (i_decrementa) begin
      r_cuenta <= r_cuenta - 1'b1;
    end
  end

  assign o_cuenta = r_cuenta;
  assign o_cero   = (r_cuenta == '0);

endmodule

// File: rtl/comparador_serial.sv
// comparador_serial: sequential magnitude comparator, MSB first, one bit per
// cycle, framed by an inicio/listo handshake.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   inicio   in   start request, only honoured in ESPERA
//   A_valor  in   K  operand A, captured when inicio is accepted
//   B_valor  in   K  operand B, captured when inicio is accepted
//   ocupado  out  comparison in progress (COMPARA or FIN)
//   listo    out  one-cycle pulse, results valid
//   A_mayor  out  A > B
//   B_mayor  out  B > A
//   iguales  out  A == B
//   indice   out  IW  bit position of the first difference (0 if equal)
// Build option: define SALIDA_TEMPRANA_EN to leave COMPARA as soon as the
// first difference is recorded; otherwise all K bits are always scanned.
module comparador_serial
  import comparador_pkg::*;
#(
  parameter int K  = 5,
  parameter int IW = calc_iw(K)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inicio,
  input  logic [K-1:0]  A_valor,
  input  logic [K-1:0]  B_valor,
  output logic          ocupado,
  output logic          listo,
  output logic          A_mayor,
  output logic          B_mayor,
  output logic          iguales,
  output logic [IW-1:0] indice
);

  estado_t       r_estado;
  estado_t       w_estado_next;
  logic [K-1:0]  r_a;
  logic [K-1:0]  r_b;
  logic [2:0]    r_res;
  logic [IW-1:0] r_indice;
  logic          r_decidido;
  logic          r_ocupado;
  logic          r_listo;

  logic          w_carga;
  logic          w_decrementa;
  logic [IW-1:0] w_idx;
  logic          w_idx_cero;
  logic          w_bit_a;
  logic          w_bit_b;
  logic          w_difiere;

  contador_bits #(.IW(IW)) u_contador (
    .clk          (clk),
    .reset        (reset),
    .i_carga      (w_carga),
    .i_valor      (IW'(K - 1)),
    .i_decrementa (w_decrementa),
    .o_cuenta     (w_idx),
    .o_cero       (w_idx_cero)
  );

  assign w_bit_a = r_a[w_idx];
  assign w_bit_b = r_b[w_idx];

  // Only the first differing bit counts; later ones are ignored.
  assign w_difiere = (r_estado == COMPARA) && !r_decidido && (w_bit_a != w_bit_b);

  always_comb begin
    w_estado_next = r_estado;
    w_carga       = 1'b0;
    w_decrementa  = 1'b0;
    case (r_estado)
      ESPERA: begin
        if (inicio) begin
          w_estado_next = COMPARA;
          w_carga       = 1'b1;
        end
      end
      COMPARA: begin
        if (w_idx_cero) begin
          w_estado_next = FIN;
        end else begin
          w_decrementa = 1'b1;
        end
`ifdef SALIDA_TEMPRANA_EN
        // A stray decrement on the exit cycle is harmless: the counter is
        // reloaded on the next start.
        if (w_difiere) begin
          w_estado_next = FIN;
        end
`endif
      end
      FIN: begin
        w_estado_next = ESPERA;
      end
      default: begin
        w_estado_next = ESPERA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado   <= ESPERA;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= RES_NINGUNO;
      r_indice   <= '0;
      r_decidido <= 1'b0;
      r_ocupado  <= 1'b0;
      r_listo    <= 1'b0;
    end else begin
      r_estado  <= w_estado_next;
      // Status flags are registered from the next state so they line up
      // exactly with the state they describe.
      r_ocupado <= (w_estado_next != ESPERA);
      r_listo   <= (w_estado_next == FIN);

      if (w_carga) begin
        r_a        <= A_valor;
        r_b        <= B_valor;
        r_res      <= RES_NINGUNO;
        r_indice   <= '0;
        r_decidido <= 1'b0;
      end

      if (w_difiere) begin
        r_res      <= w_bit_a ? RES_A_MAYOR : RES_B_MAYOR;
        r_indice   <= w_idx;
        r_decidido <= 1'b1;
      end

      // Equality is flagged on the edge entering FIN so it is visible
      // together with listo.
      if ((r_estado == COMPARA) && (w_estado_next == FIN) && !r_decidido && !w_difiere) begin
        r_res <= RES_IGUALES;
      end
    end
  end

  assign ocupado = r_ocupado;
  assign listo   = r_listo;
  assign A_mayor = r_res[2];
  assign B_mayor = r_res[1];
  assign iguales = r_res[0];
  assign indice  = r_indice;

endmodule

// File: tb/tb_comparador_serial.sv
// tb_comparador_serial: randomized scoreboard bench for comparador_serial.
// The driver pushes the expected result and listo cycle of every accepted
// comparison into a queue; an independent monitor samples the outputs 1 time
// unit after each rising edge and pops/compares when listo is due.
module tb_comparador_serial;

  localparam int K  = 5;
  localparam int IW = 3;

  typedef struct {
    logic [K-1:0]  a;
    logic [K-1:0]  b;
    logic          am;
    logic          bm;
    logic          ig;
    logic [IW-1:0] idx;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          inicio;
  logic [K-1:0]  A_valor;
  logic [K-1:0]  B_valor;
  logic          ocupado;
  logic          listo;
  logic          A_mayor;
  logic          B_mayor;
  logic          iguales;
  logic [IW-1:0] indice;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t ultimo;
  bit   have_last = 1'b0;
  int   busy_s = 1;
  int   busy_e = 0;

  comparador_serial #(.K(K)) dut (
    .clk     (clk),
    .reset   (reset),
    .inicio  (inicio),
    .A_valor (A_valor),
    .B_valor (B_valor),
    .ocupado (ocupado),
    .listo   (listo),
    .A_mayor (A_mayor),
    .B_mayor (B_mayor),
    .iguales (iguales),
    .indice  (indice)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: obtenido=%0h requerido=%0h (t=%0t)", nombre, act, req, $time);
    end
  endtask

  // Reference: plain magnitude comparison; index = highest bit of A^B.
  function automatic exp_t modelo(input logic [K-1:0] a, input logic [K-1:0] b, input int e);
    exp_t r;
    int   j = -1;
    int   n;
    for (int i = K - 1; i >= 0; i--) begin
      if (j < 0 && a[i] != b[i]) j = i;
    end
    r.a   = a;
    r.b   = b;
    r.am  = (a > b);
    r.bm  = (b > a);
    r.ig  = (a == b);
    r.idx = (j >= 0) ? IW'(j) : '0;
    n = K;
`ifdef SALIDA_TEMPRANA_EN
    if (j >= 0) n = K - j;
`endif
    r.cyc = e + n;  // listo is seen in cycle N+1, i.e. after edge e+N
    return r;
  endfunction

  task automatic ocioso(input int n);
    repeat (n) begin
      @(negedge clk);
      inicio  = 1'b0;
      A_valor = K'($urandom);
      B_valor = K'($urandom);
    end
  endtask

  // Starts a comparison; while it runs the operands are scrambled and inicio
  // is held high (mantener) or toggled randomly. abortar>0 asserts reset in
  // that cycle of the comparison.
  task automatic arrancar(input logic [K-1:0] a, input logic [K-1:0] b,
                          input bit mantener, input int abortar);
    exp_t x;
    int   e;
    int   n;
    @(negedge clk);
    A_valor = a;
    B_valor = b;
    inicio  = 1'b1;
    e = cyc + 1;
    x = modelo(a, b, e);
    n = x.cyc - e;
    q.push_back(x);
    busy_s    = e;
    busy_e    = e + n;
    have_last = 1'b0;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      A_valor = K'($urandom);
      B_valor = K'($urandom);
      inicio  = mantener ? 1'b1 : 1'($urandom_range(0, 1));
      if (abortar > 0 && k == abortar - 1) begin
        reset  = 1'b1;
        inicio = 1'b1;
        q.delete();
        busy_s    = 1;
        busy_e    = 0;
        have_last = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        inicio = 1'b0;
        chk("reset_cero", {ocupado, listo, A_mayor, B_mayor, iguales, indice}, 0);
        return;
      end
    end
  endtask

  // Monitor
  initial begin
    exp_t x;
    bit   exp_busy;
    forever begin
      @(posedge clk);
      #1;
      exp_busy = (cyc >= busy_s) && (cyc <= busy_e);
      chk("ocupado", ocupado, exp_busy);
      if (q.size() > 0 && cyc == q[0].cyc) begin
        x = q.pop_front();
        chk("listo", listo, 1);
        chk("A_mayor", A_mayor, x.am);
        chk("B_mayor", B_mayor, x.bm);
        chk("iguales", iguales, x.ig);
        chk("indice", indice, x.idx);
        $display("txn A=%b B=%b -> A_mayor=%0b B_mayor=%0b iguales=%0b indice=%0d ciclo=%0d",
                 x.a, x.b, A_mayor, B_mayor, iguales, indice, cyc);
        ultimo    = x;
        have_last = 1'b1;
      end else begin
        chk("listo_inactivo", listo, 0);
        if (!exp_busy && have_last) begin
          chk("retencion", {A_mayor, B_mayor, iguales, indice},
              {ultimo.am, ultimo.bm, ultimo.ig, ultimo.idx});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: obtenido=timeout requerido=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [K-1:0] a;
    logic [K-1:0] b;
    reset   = 1'b1;
    inicio  = 1'b1;  // must be ignored while reset is high
    A_valor = 5'b11111;
    B_valor = 5'b00000;
    repeat (3) @(negedge clk);
    chk("reset_inicial", {ocupado, listo, A_mayor, B_mayor, iguales, indice}, 0);
    reset  = 1'b0;
    inicio = 1'b0;
    ocioso(2);

    arrancar(5'b11100, 5'b01101, 1'b0, 0);
    ocioso(1);
    arrancar(5'b10001, 5'b10110, 1'b0, 0);
    ocioso(2);
    arrancar(5'b10101, 5'b10100, 1'b0, 0);
    ocioso(1);
    // inicio held high throughout, next comparison accepted back-to-back
    arrancar(5'b10101, 5'b10101, 1'b1, 0);
    arrancar(5'b11100, 5'b10001, 1'b0, 0);
    ocioso(2);
    // abort mid-comparison
    arrancar(5'b10101, 5'b10101, 1'b0, 3);
    ocioso(3);

    for (int t = 0; t < 40; t++) begin
      a = K'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (K'(1) << $urandom_range(0, K - 1));
        default: b = K'($urandom);
      endcase
      arrancar(a, b, 1'($urandom_range(0, 1)), 0);
      ocioso($urandom_range(0, 2));
    end

    ocioso(4);
    chk("cola_vacia", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
